// File: rtl/cla_acc_64bit_if.sv
// Operand/result stream bundle for the 64-bit carry-lookahead accumulator.
// The slave modport is the accumulator side; the master modport is the environment side.
interface cla_acc_if #(
   parameter int COUNT_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [63:0]        in_data;
   logic               in_cin;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [63:0]        out_sum;
   logic [COUNT_W-1:0] out_carries;
   logic [COUNT_W-1:0] out_beats;

   modport slave (
      input  in_valid, in_data, in_cin, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_carries, out_beats
   );

   modport master (
      output in_valid, in_data, in_cin, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_carries, out_beats
   );
endinterface

// File: rtl/cla_acc_64bit.sv
// Framed 64-bit stream accumulator wrapped around a combinational CLA adder.
// Reports the sum, the bit-63 carry-out count and the beat count per frame.
module cla_64bit (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   logic [63:0] g;
   logic [63:0] p;
   logic [64:0] c;
   logic [15:0] gg;
   logic [15:0] gp;

   // 4-bit lookahead groups; group generate/propagate chain the group carries
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      gg   = '0;
      gp   = '0;
      c[0] = cin;
      for (int k = 0; k < 16; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1]
                  | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2]
                  | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
      end
      sum  = p ^ c[63:0];
      cout = c[64];
   end
endmodule

module cla_acc_64bit #(
   parameter int COUNT_W = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   cla_acc_if.slave  bus
);
   localparam logic [0:0] ACC  = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [63:0]        acc_q, acc_d;
   logic [COUNT_W-1:0] carry_q, carry_d;
   logic [COUNT_W-1:0] beat_q, beat_d;
   logic [63:0]        sum_q, sum_d;
   logic [COUNT_W-1:0] carries_q, carries_d;
   logic [COUNT_W-1:0] beats_q, beats_d;

   logic [63:0]        add_sum;
   logic               add_cout;
   logic [COUNT_W-1:0] carry_inc;
   logic [COUNT_W-1:0] beat_inc;
   logic               in_xfer;

   cla_64bit u_cla (
      .a    (acc_q),
      .b    (bus.in_data),
      .cin  (bus.in_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign bus.in_ready    = rst_n & (state_q == ACC);
   assign bus.out_valid   = (state_q == HOLD);
   assign bus.out_sum     = sum_q;
   assign bus.out_carries = carries_q;
   assign bus.out_beats   = beats_q;
   assign in_xfer         = bus.in_valid & bus.in_ready;

   always_comb begin
      carry_inc = carry_q;
      if (carry_q != '1)
         carry_inc = carry_q + {{(COUNT_W-1){1'b0}}, add_cout};
      beat_inc = beat_q;
      if (beat_q != '1)
         beat_inc = beat_q + COUNT_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      beat_d    = beat_q;
      sum_d     = sum_q;
      carries_d = carries_q;
      beats_d   = beats_q;
      if (state_q == ACC) begin
         if (in_xfer && bus.in_last) begin
            sum_d     = add_sum;
            carries_d = carry_inc;
            beats_d   = beat_inc;
            acc_d     = '0;
            carry_d   = '0;
            beat_d    = '0;
            state_d   = HOLD;
         end else if (in_xfer) begin
            acc_d   = add_sum;
            carry_d = carry_inc;
            beat_d  = beat_inc;
         end
      end else if (bus.out_ready) begin
         state_d = ACC;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         carry_q   <= '0;
         beat_q    <= '0;
         sum_q     <= '0;
         carries_q <= '0;
         beats_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         beat_q    <= beat_d;
         sum_q     <= sum_d;
         carries_q <= carries_d;
         beats_q   <= beats_d;
      end
   end
endmodule

// File: tb/tb_cla_acc_64bit.sv
// Directed bench for cla_acc_64bit: default-width instance plus a
// COUNT_W=2 instance for counter saturation.
module tb_cla_acc_64bit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cla_acc_if #(.COUNT_W(8)) if0 ();
   cla_acc_if #(.COUNT_W(2)) if1 ();

   cla_acc_64bit #(.COUNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   cla_acc_64bit #(.COUNT_W(2)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat0(input logic [63:0] d, input logic ci,
                        input logic last, input string nm);
      if0.in_valid = 1'b1;
      if0.in_data  = d;
      if0.in_cin   = ci;
      if0.in_last  = last;
      checks++;
      if (if0.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready: got %b want 1", nm, if0.in_ready);
      end
      tick();
      if0.in_valid = 1'b0;
      if0.in_last  = 1'b0;
   endtask

   task automatic result0(input logic [63:0] s, input logic [7:0] c,
                          input logic [7:0] b, input string nm);
      checks++;
      if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s hold: out_valid %b in_ready %b want 1 0",
                  nm, if0.out_valid, if0.in_ready);
      end
      checks++;
      if (if0.out_sum !== s) begin
         errors++;
         $display("FAIL %s sum: got %0d want %0d", nm, if0.out_sum, s);
      end
      checks++;
      if (if0.out_carries !== c || if0.out_beats !== b) begin
         errors++;
         $display("FAIL %s counts: got %0d/%0d want %0d/%0d",
                  nm, if0.out_carries, if0.out_beats, c, b);
      end
      if0.out_ready = 1'b1;
      tick();
      if0.out_ready = 1'b0;
      checks++;
      if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: out_valid %b in_ready %b want 0 1",
                  nm, if0.out_valid, if0.in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if0.in_valid = 1'b1;
      if0.in_data  = 64'd99;
      if0.in_last  = 1'b1;
      if1.in_valid = 1'b1;
      if1.in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (if0.in_ready !== 1'b0 || if1.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b %b want 0 0",
                     if0.in_ready, if1.in_ready);
         end
      end
      checks++;
      if (if0.out_valid !== 1'b0 || if0.out_sum !== 64'd0 ||
          if0.out_carries !== 8'd0 || if0.out_beats !== 8'd0) begin
         errors++;
         $display("FAIL reset_out: valid %b sum %0d c %0d b %0d want 0",
                  if0.out_valid, if0.out_sum, if0.out_carries, if0.out_beats);
      end
      checks++;
      if (if1.out_valid !== 1'b0 || if1.out_sum !== 64'd0) begin
         errors++;
         $display("FAIL reset_out_sat: valid %b sum %0d want 0 0",
                  if1.out_valid, if1.out_sum);
      end
      if0.in_valid = 1'b0;
      if0.in_last  = 1'b0;
      if1.in_valid = 1'b0;
      if1.in_last  = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready %b out_valid %b want 1 0",
                  if0.in_ready, if0.out_valid);
      end
   endtask

   task automatic test_multi_beat();
      beat0(64'd20, 1'b0, 1'b0, "multi_b0");
      checks++;
      if (if0.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL multi_early: out_valid %b want 0", if0.out_valid);
      end
      beat0(64'd55, 1'b1, 1'b0, "multi_b1");
      beat0(64'd133, 1'b0, 1'b1, "multi_b2");
      result0(64'd209, 8'd0, 8'd3, "multi");
   endtask

   task automatic test_wrap();
      beat0(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "wrap_b0");
      beat0(64'd2, 1'b0, 1'b1, "wrap_b1");
      result0(64'd1, 8'd1, 8'd1 + 8'd1, "wrap");
   endtask

   task automatic test_backpressure();
      beat0(64'd4223372036854775808, 1'b1, 1'b1, "bp_beat");
      if0.in_valid = 1'b1;
      if0.in_data  = 64'd7;
      if0.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 ||
             if0.out_sum !== 64'd4223372036854775809) begin
            errors++;
            $display("FAIL bp_hold: rdy %b vld %b sum %0d want 0 1 %0d",
                     if0.in_ready, if0.out_valid, if0.out_sum,
                     64'd4223372036854775809);
         end
      end
      if0.in_valid = 1'b0;
      if0.in_last  = 1'b0;
      result0(64'd4223372036854775809, 8'd0, 8'd1, "bp");
      beat0(64'd5, 1'b0, 1'b1, "bp_after");
      result0(64'd5, 8'd0, 8'd1, "bp_after");
   endtask

   task automatic test_back_to_back();
      beat0(64'd1000, 1'b0, 1'b1, "b2b_f0");
      result0(64'd1000, 8'd0, 8'd1, "b2b_f0");
      beat0(64'h8000_0000_0000_0000, 1'b0, 1'b0, "b2b_f1a");
      beat0(64'h8000_0000_0000_0000, 1'b1, 1'b1, "b2b_f1b");
      result0(64'd1, 8'd1, 8'd2, "b2b_f1");
   endtask

   task automatic test_saturation();
      if1.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      if1.in_cin   = 1'b0;
      if1.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if1.in_last = (i == 4);
         tick();
      end
      if1.in_valid = 1'b0;
      if1.in_last  = 1'b0;
      checks++;
      if (if1.out_valid !== 1'b1 || if1.out_sum !== 64'hFFFF_FFFF_FFFF_FFFB) begin
         errors++;
         $display("FAIL sat_sum: valid %b sum %h want 1 fffffffffffffffb",
                  if1.out_valid, if1.out_sum);
      end
      checks++;
      if (if1.out_carries !== 2'd3 || if1.out_beats !== 2'd3) begin
         errors++;
         $display("FAIL sat_counts: got %0d/%0d want 3/3",
                  if1.out_carries, if1.out_beats);
      end
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
      checks++;
      if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL sat_release: vld %b rdy %b want 0 1",
                  if1.out_valid, if1.in_ready);
      end
   endtask

   task automatic test_mid_reset();
      beat0(64'd3748, 1'b0, 1'b0, "mr_b0");
      beat0(64'd9786, 1'b1, 1'b0, "mr_b1");
      rst_n = 1'b0;
      #1;
      checks++;
      if (if0.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mr_ready: got %b want 0", if0.in_ready);
      end
      tick();
      rst_n = 1'b1;
      #1;
      beat0(64'd24, 1'b1, 1'b1, "mr_b2");
      result0(64'd25, 8'd0, 8'd1, "mr");
   endtask

   initial begin
      if0.in_valid  = 1'b0;
      if0.in_data   = '0;
      if0.in_cin    = 1'b0;
      if0.in_last   = 1'b0;
      if0.out_ready = 1'b0;
      if1.in_valid  = 1'b0;
      if1.in_data   = '0;
      if1.in_cin    = 1'b0;
      if1.in_last   = 1'b0;
      if1.out_ready = 1'b0;
      test_reset();
      test_multi_beat();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
